// File: rtl/wall_clock_pkg.sv
// Shared time constants, BCD helpers and the active-low seven-segment encoding
// used by the wall clock.
package wall_clock_pkg;

   localparam logic [5:0] SEC_MAX  = 6'd59;
   localparam logic [5:0] MIN_MAX  = 6'd59;
   localparam logic [4:0] HOUR_MAX = 5'd23;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd_t;

   function automatic bcd_t to_bcd(input logic [5:0] value);
      bcd_t r;
      r.tens = 4'(value / 6'd10);
      r.ones = 4'(value % 6'd10);
      return r;
   endfunction

   localparam bcd_t MIN_MAX_BCD  = to_bcd(MIN_MAX);
   localparam bcd_t HOUR_MAX_BCD = to_bcd(6'(HOUR_MAX));

   // Two-digit BCD increment that wraps to 00 after reaching max.
   function automatic bcd_t bcd_inc(input bcd_t value, input bcd_t max);
      bcd_t r;
      if (value == max) begin
         r = '0;
      end else if (value.ones == 4'd9) begin
         r.tens = value.tens + 4'd1;
         r.ones = 4'd0;
      end else begin
         r.tens = value.tens;
         r.ones = value.ones + 4'd1;
      end
      return r;
   endfunction

   // Active-low {dp,g,f,e,d,c,b,a}; decimal point always off.
   function automatic logic [7:0] seg_encode(input logic [3:0] digit);
      case (digit)
         4'd0:    return 8'hC0;
         4'd1:    return 8'hF9;
         4'd2:    return 8'hA4;
         4'd3:    return 8'hB0;
         4'd4:    return 8'h99;
         4'd5:    return 8'h92;
         4'd6:    return 8'h82;
         4'd7:    return 8'hF8;
         4'd8:    return 8'h80;
         4'd9:    return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/wall_clock_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-high debounce counter
// and a single one-cycle pulse per press (no auto-repeat).
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic pulse_out
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync      <= '0;
         cnt       <= '0;
         pulse_out <= 1'b0;
      end else begin
         sync      <= {sync[0], btn_in};
         pulse_out <= 1'b0;
         // Counter saturates at CNT_DONE so a held button fires only once.
         if (!sync[1]) begin
            cnt <= '0;
         end else if (cnt != CNT_DONE) begin
            cnt       <= cnt + CNT_W'(1);
            pulse_out <= (cnt == CNT_LAST);
         end
      end
   end

endmodule

// File: rtl/wall_clock.sv
// 24-hour wall clock: seconds on LEDs, HH:MM on a multiplexed active-low
// seven-segment display with PWM dimming, buttons to advance minutes/hours.
module wall_clock
   import wall_clock_pkg::*;
#(
   parameter int CLK_HZ          = 100_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REFRESH_CYCLES  = 100_000
) (
   input  logic       CLK100MHZ,
   input  logic       RESET_BTN,
   input  logic       INC_MIN,
   input  logic       INC_HOUR,
   input  logic [7:0] pwm_in,
   output logic [5:0] LED,
   output logic [7:0] SevenSegment,
   output logic [7:0] SegmentDrivers
);

   localparam int               TICK_W    = $clog2(CLK_HZ + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
   localparam int               REF_W     = $clog2(REFRESH_CYCLES + 1);
   localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_CYCLES - 1);

   logic [TICK_W-1:0] tick_cnt;
   logic [REF_W-1:0]  ref_cnt;
   logic [1:0]        digit_idx;
   logic [7:0]        pwm_cnt;
   logic [5:0]        sec;
   bcd_t              min_bcd, hour_bcd;
   logic              min_pulse, hour_pulse;

   logic              tick, sec_carry, min_carry;
   logic [5:0]        sec_next;
   bcd_t              min_btn, min_next, hour_btn, hour_next;
   logic [3:0]        digit;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_min_btn (
      .clk(CLK100MHZ), .rst(RESET_BTN), .btn_in(INC_MIN), .pulse_out(min_pulse)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hour_btn (
      .clk(CLK100MHZ), .rst(RESET_BTN), .btn_in(INC_HOUR), .pulse_out(hour_pulse)
   );

   // Button increment is applied first; the tick carry then advances the result,
   // so only the carry path crossing its max ripples into the next field.
   always_comb begin
      tick      = (tick_cnt == TICK_LAST);
      sec_carry = tick && (sec == SEC_MAX);
      sec_next  = sec;
      if (tick) sec_next = sec_carry ? 6'd0 : sec + 6'd1;

      min_btn   = min_pulse ? bcd_inc(min_bcd, MIN_MAX_BCD) : min_bcd;
      min_carry = sec_carry && (min_btn == MIN_MAX_BCD);
      min_next  = sec_carry ? bcd_inc(min_btn, MIN_MAX_BCD) : min_btn;

      hour_btn  = hour_pulse ? bcd_inc(hour_bcd, HOUR_MAX_BCD) : hour_bcd;
      hour_next = min_carry ? bcd_inc(hour_btn, HOUR_MAX_BCD) : hour_btn;

      // NOTE: every combinational output gets a default before the case so no latch is inferred.
      digit = min_bcd.ones;
      case (digit_idx)
         2'd0: digit = min_bcd.ones;
         2'd1: digit = min_bcd.tens;
         2'd2: digit = hour_bcd.ones;
         2'd3: digit = hour_bcd.tens;
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (RESET_BTN) begin
         tick_cnt       <= '0;
         ref_cnt        <= '0;
         digit_idx      <= '0;
         pwm_cnt        <= '0;
         sec            <= '0;
         min_bcd        <= '0;
         hour_bcd       <= '0;
         SevenSegment   <= 8'hFF;
         SegmentDrivers <= 8'hFF;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
         sec      <= sec_next;
         min_bcd  <= min_next;
         hour_bcd <= hour_next;

         if (ref_cnt == REF_LAST) begin
            ref_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
         end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
         end

         pwm_cnt        <= pwm_cnt + 8'd1;
         SevenSegment   <= seg_encode(digit);
         SegmentDrivers <= (pwm_cnt < pwm_in) ? {4'hF, ~(4'b0001 << digit_idx)} : 8'hFF;
      end
   end

   assign LED = sec;

endmodule

// File: tb/tb_wall_clock.sv
// Directed self-checking bench for wall_clock with shortened timing
// (CLK_HZ = 10, DEBOUNCE_CYCLES = 4, REFRESH_CYCLES = 2).
module tb_wall_clock;

   logic       CLK100MHZ = 1'b0;
   logic       RESET_BTN = 1'b1;
   logic       INC_MIN   = 1'b0;
   logic       INC_HOUR  = 1'b0;
   logic [7:0] pwm_in    = 8'd255;
   logic [5:0] LED;
   logic [7:0] SevenSegment;
   logic [7:0] SegmentDrivers;

   localparam logic [7:0] SEG_TABLE [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   wall_clock #(
      .CLK_HZ(10), .DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(2)
   ) dut (
      .CLK100MHZ(CLK100MHZ), .RESET_BTN(RESET_BTN), .INC_MIN(INC_MIN),
      .INC_HOUR(INC_HOUR), .pwm_in(pwm_in), .LED(LED),
      .SevenSegment(SevenSegment), .SegmentDrivers(SegmentDrivers)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   // Clock edges since the last edge that sampled reset high.
   always @(posedge CLK100MHZ) cyc <= RESET_BTN ? 0 : cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge CLK100MHZ);
   endtask

   task automatic do_reset();
      RESET_BTN = 1'b1;
      repeat (2) @(negedge CLK100MHZ);
      RESET_BTN = 1'b0;
   endtask

   task automatic press(input logic hour);
      if (hour) INC_HOUR = 1'b1;
      else      INC_MIN  = 1'b1;
      repeat (7) @(negedge CLK100MHZ);
      INC_HOUR = 1'b0;
      INC_MIN  = 1'b0;
      repeat (3) @(negedge CLK100MHZ);
   endtask

   task automatic read_digit(input string tag, input int idx, output logic [7:0] seg);
      logic [7:0] pat;
      logic       found;
      pat      = 8'hFF;
      pat[idx] = 1'b0;
      seg      = 8'h00;
      found    = 1'b0;
      for (int k = 0; k < 32 && !found; k++) begin
         @(negedge CLK100MHZ);
         if (SegmentDrivers == pat) begin
            seg   = SevenSegment;
            found = 1'b1;
         end
      end
      check({tag, "_anode_seen"}, int'(found), 1);
   endtask

   task automatic check_time(input string tag, input int hh, input int mm);
      logic [7:0] s;
      read_digit(tag, 3, s); check({tag, "_h_tens"}, int'(s), int'(SEG_TABLE[hh / 10]));
      read_digit(tag, 2, s); check({tag, "_h_ones"}, int'(s), int'(SEG_TABLE[hh % 10]));
      read_digit(tag, 1, s); check({tag, "_m_tens"}, int'(s), int'(SEG_TABLE[mm / 10]));
      read_digit(tag, 0, s); check({tag, "_m_ones"}, int'(s), int'(SEG_TABLE[mm % 10]));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int active;

      // Reset state and seconds counting through a full minute.
      repeat (3) @(negedge CLK100MHZ);
      check("rst_led", int'(LED), 0);
      check("rst_seg", int'(SevenSegment), 'hFF);
      check("rst_an", int'(SegmentDrivers), 'hFF);
      RESET_BTN = 1'b0;
      for (int n = 1; n <= 600; n++) begin
         @(negedge CLK100MHZ);
         check("s1_led", int'(LED), (n / 10) % 60);
      end
      check_time("s1", 0, 1);

      // Preload 23:59 by buttons, let seconds reach 59, then one tick wraps all.
      do_reset();
      for (int i = 0; i < 23; i++) press(1'b1);
      for (int i = 0; i < 58; i++) press(1'b0);
      check_time("s2_pre", 23, 59);
      wait_until(1195);
      check("s2_led59", int'(LED), 59);
      wait_until(1203);
      check("s2_led_wrap", int'(LED), 0);
      check_time("s2_wrap", 0, 0);

      // Long hold gives one minute; a short glitch gives none.
      INC_MIN = 1'b1;
      repeat (20) @(negedge CLK100MHZ);
      INC_MIN = 1'b0;
      repeat (5) @(negedge CLK100MHZ);
      check_time("s3_hold", 0, 1);
      INC_MIN = 1'b1;
      repeat (3) @(negedge CLK100MHZ);
      INC_MIN = 1'b0;
      repeat (10) @(negedge CLK100MHZ);
      check_time("s3_glitch", 0, 1);
      check("s3_led", int'(LED), (cyc / 10) % 60);

      // Brightness: blank at 0, half duty at 128.
      pwm_in = 8'd0;
      repeat (2) @(negedge CLK100MHZ);
      active = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK100MHZ);
         if (SegmentDrivers != 8'hFF) active++;
      end
      check("pwm0_active", active, 0);
      pwm_in = 8'd128;
      repeat (2) @(negedge CLK100MHZ);
      active = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge CLK100MHZ);
         if (SegmentDrivers != 8'hFF) active++;
      end
      check("pwm128_active", active, 128);
      pwm_in = 8'd255;

      // INC_MIN pulse lands on the same edge as the seconds carry at minute 58.
      do_reset();
      for (int i = 0; i < 57; i++) press(1'b0);
      wait_until(605);
      check_time("s4_pre", 0, 58);
      wait_until(1193);
      INC_MIN = 1'b1;
      repeat (7) @(negedge CLK100MHZ);
      INC_MIN = 1'b0;
      repeat (5) @(negedge CLK100MHZ);
      check("s4_led", int'(LED), 0);
      check_time("s4_post", 1, 0);

      // Reset in the middle of 12:34:56.
      do_reset();
      for (int i = 0; i < 12; i++) press(1'b1);
      for (int i = 0; i < 34; i++) press(1'b0);
      check_time("s6_pre", 12, 34);
      wait_until(565);
      check("s6_led56", int'(LED), 56);
      RESET_BTN = 1'b1;
      @(negedge CLK100MHZ);
      check("s6_rst_led", int'(LED), 0);
      check("s6_rst_seg", int'(SevenSegment), 'hFF);
      check("s6_rst_an", int'(SegmentDrivers), 'hFF);
      RESET_BTN = 1'b0;
      wait_until(9);
      check("s6_led_pre_tick", int'(LED), 0);
      wait_until(10);
      check("s6_led_tick", int'(LED), 1);
      check_time("s6_post", 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wall_clock.md
# wall_clock

Top-level 24-hour wall clock for the 100 MHz FPGA board. It keeps hours, minutes and seconds, and shows the seconds count in binary on six LEDs. It shows HH:MM on a multiplexed, active-low 8-digit seven-segment display, with PWM brightness control. Two debounced push-buttons advance minutes and hours.

## Interface
Parameters:
- CLK_HZ, 100_000_000, clock cycles per one-second tick.
- DEBOUNCE_CYCLES, 1_000_000, cycles a button must be stable high before it registers (10 ms).
- REFRESH_CYCLES, 100_000, cycles each digit stays selected (1 ms per digit).

Ports:
- CLK100MHZ  in  1  system clock, 100 MHz.
- RESET_BTN  in  1  reset: one clock; reset is synchronous and active-high.
- INC_MIN  in  1  raw push-button, active-high; advances minutes.
- INC_HOUR  in  1  raw push-button, active-high; advances hours.
- pwm_in  in  8  display brightness duty value (0 = blank).
- LED  out  6  current seconds, unsigned binary, 0–59.
- SevenSegment  out  8  active-low cathodes, {dp,g,f,e,d,c,b,a}.
- SegmentDrivers  out  8  active-low digit anodes; bit 0 is the rightmost digit.

## Operation
Timekeeping:
- A tick counter counts 0..CLK_HZ-1. On its terminal count it raises a one-cycle `tick` and wraps to 0.
- On `tick`, seconds increment. Seconds wrap 59→0.
- The seconds wrap carries into minutes. Minutes wrap 59→0.
- The minutes wrap carries into hours. Hours wrap 23→0.

Button handling:
- Each button is synchronised through 2 flops, then debounced.
- A debounced rising edge produces exactly one one-cycle pulse per press. Holding a button produces no auto-repeat.
- An INC_MIN pulse increments minutes mod 60. It never carries into hours and leaves seconds and the tick counter unchanged.
- An INC_HOUR pulse increments hours mod 24.

Simultaneous events: every event landing in the same cycle is applied.
- INC_MIN pulse plus a seconds carry: minutes advance by 2 mod 60. A carry into hours is generated only if the tick-carry path crosses 59→0.
- INC_HOUR pulse plus a minutes carry: hours advance by 2 mod 24.

Display:
- Time is stored as BCD digits: h_tens (0–2), h_ones, m_tens (0–5), m_ones.
- Digit mapping: index 0 = m_ones on anode bit 0; 1 = m_tens; 2 = h_ones; 3 = h_tens.
- Anode bits 7:4 are always 1 (off). Leading zeros are shown.
- The digit index cycles 0→1→2→3→0, advancing every REFRESH_CYCLES clocks.
- The selected anode bit is 0 and all other anode bits are 1.
- Decimal point is always off (SevenSegment[7] = 1).
- Active-low patterns for digits 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex).

Brightness:
- A free-running 8-bit counter increments every clock.
- The display is enabled while counter < pwm_in.
- While disabled, SegmentDrivers = FF. SevenSegment keeps the current pattern.
- pwm_in = 0 gives a blank display; pwm_in = 255 gives 255/256 duty.

## Timing
Reset (synchronous, sampled on the CLK100MHZ rising edge while RESET_BTN = 1):
- Time returns to 00:00:00.
- The tick, refresh, PWM and debounce counters clear.
- LED = 0, SevenSegment = FF, SegmentDrivers = FF.
- Reset has priority over every tick and button event in the same cycle.
- A button press in progress is discarded.

Output timing:
- All outputs are registered.
- LED reflects the new seconds value 1 cycle after `tick`.
- The display reflects new time within one refresh period plus 1 cycle.

Button latency:
- The increment pulse appears 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle after the input rises.
- Any input drop before the count completes restarts the debounce count.

First tick: occurs CLK_HZ cycles after reset release.

## Structure
Shared package wall_clock_pkg holds:
- the 7-segment encoding function (digit → 8-bit active-low pattern);
- constants SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23.

Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_in, pulse_out) is instantiated twice.

Counters and the display multiplexer stay in the top level.

## Test plan
Run all scenarios with CLK_HZ = 10, DEBOUNCE_CYCLES = 4, REFRESH_CYCLES = 2.
- Reset then 600 clocks → LED counts 0..59 and wraps to 0; minutes read 01; hours 00.
- Preload 23:59:59 via buttons and ticks, then one tick → 00:00:00. LED = 0; all four digits show C0.
- INC_MIN held high for 20 cycles → exactly +1 minute. A 3-cycle glitch → no change.
- INC_MIN pulse in the same cycle as a seconds carry at minute 58 → minutes = 00 and hours +1.
- pwm_in = 0 → SegmentDrivers stays FF. pwm_in = 128 → the anode is active on exactly 128 of 256 cycles.
- Assert RESET_BTN mid-count at 12:34:56 → next cycle LED = 0, SevenSegment = FF, SegmentDrivers = FF; time restarts from 00:00:00.
